// File: rtl/spart_pkg.sv
// Shared SPART types and constants: receive FSM states and oversampling helpers.
package spart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_DEFAULT  = 8;

  function automatic int tick_mid(input int oversample);
    return oversample / 2 - 1;
  endfunction

  function automatic int tick_last(input int oversample);
    return oversample - 1;
  endfunction

  localparam int TICK_MID  = tick_mid(OVERSAMPLE_DEFAULT);
  localparam int TICK_LAST = tick_last(OVERSAMPLE_DEFAULT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/spart_sync.sv
// N-stage synchroniser for asynchronous single-bit inputs, with a selectable reset level.
module spart_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: oversampled 8N1 deserialiser with data-available, framing and overrun flags.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a low level on the synchronised rxd
// START     | counting to mid start bit to reject glitches
// DATA      | sampling data bits once per bit period, LSB first
// STOP      | sampling stop bit, then loading or flagging overrun
// WAIT_IDLE | stop bit was low; wait for line high so a break cannot retrigger
module spart_rx
  import spart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enable,
  input  logic                 rxd,
  input  logic                 rd_strobe,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID      = TW'(tick_mid(OVERSAMPLE));
  localparam logic [TW-1:0] T_LAST     = TW'(tick_last(OVERSAMPLE));
  localparam logic [BW-1:0] B_LAST_IDX = BW'(DATA_BITS - 1);

  logic rxd_s;

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rda_q, rda_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;

  spart_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .d_in  (rxd),
    .d_out (rxd_s)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rda_d   = rda_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;

    // A read clears the flags; a completion on the same edge overrides below.
    if (rd_strobe) begin
      rda_d = 1'b0;
      fe_d  = 1'b0;
      ovr_d = 1'b0;
    end

    if (rx_enable) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == T_MID) begin
            if (rxd_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        DATA: begin
          if (tick_q == T_LAST) begin
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + BW'(1);
            if (bit_q == B_LAST_IDX) begin
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        STOP: begin
          if (tick_q == T_LAST) begin
            if (rda_q && !rd_strobe) begin
              ovr_d = 1'b1;
            end else begin
              data_d = shift_q;
              rda_d  = 1'b1;
              fe_d   = ~rxd_s;
            end
            tick_d  = '0;
            state_d = rxd_s ? IDLE : WAIT_IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rxd_s) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rda_q   <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rda_q   <= rda_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rda         = rda_q;
  assign framing_err = fe_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: table of framed bytes plus hand sequences for glitch, break, reset and stuck enable.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_enable;
  logic       rxd;
  logic       rd_strobe;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int en_div  = 1;
  int en_cnt  = 0;
  bit en_stuck = 1'b0;

  spart_rx #(
    .DATA_BITS   (8),
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_enable   (rx_enable),
    .rxd         (rxd),
    .rd_strobe   (rd_strobe),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Oversample tick: one clk wide, every en_div clocks.
  initial begin
    rx_enable = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (en_stuck) begin
        rx_enable = 1'b0;
      end else begin
        en_cnt    = (en_cnt + 1) % en_div;
        rx_enable = (en_cnt == 0);
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pre_read;
    logic       strobe_done;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_rda;
    logic       exp_fe;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_pulse();
    @(posedge clk);
    #1;
    rd_strobe = 1'b1;
    @(posedge clk);
    #1;
    rd_strobe = 1'b0;
  endtask

  // Edge 0 is the edge just before rxd falls; rxd changes 1 time unit after each edge.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int bit_clks,
                            input int strobe_edge, input int rst_edge,
                            output logic rda_154, output logic rda_155);
    logic [9:0] frame;
    frame   = {stop, data, 1'b0};
    rda_154 = 1'bx;
    rda_155 = 1'bx;
    @(posedge clk);
    #1;
    rxd       = frame[0];
    rd_strobe = (strobe_edge == 1);
    for (int e = 1; e < 10 * bit_clks; e++) begin
      @(posedge clk);
      #1;
      rxd       = frame[e / bit_clks];
      rd_strobe = (e == strobe_edge - 1);
      if (e == 154) rda_154 = rda;
      if (e == 155) rda_155 = rda;
      if (e == rst_edge) begin
        rst = 1'b1;
        #1;
        check("rst_mid_rda", rda, 0);
        check("rst_mid_data", rx_data, 0);
        check("rst_mid_fe", framing_err, 0);
        check("rst_mid_ovr", overrun, 0);
        #1;
        rst = 1'b0;
      end
    end
    rd_strobe = 1'b0;
  endtask

  initial begin
    logic       r154, r155;
    logic [7:0] prev_data;

    //           data   stop pre  sdone gap  exp_data rda fe ovr
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 4,  8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h11, 1'b1, 1'b1, 1'b0, 0,  8'h11, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h22, 1'b1, 1'b0, 1'b0, 4,  8'h11, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h77, 1'b1, 1'b0, 1'b1, 4,  8'h77, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 4,  8'h00, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hC3, 1'b0, 1'b1, 1'b0, 32, 8'hC3, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h81, 1'b0, 1'b0, 1'b0, 32, 8'hC3, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{8'hFF, 1'b1, 1'b1, 1'b0, 4,  8'hFF, 1'b1, 1'b0, 1'b0};

    rst       = 1'b1;
    rxd       = 1'b1;
    rd_strobe = 1'b0;
    wait_clks(3);
    check("reset_data", rx_data, 0);
    check("reset_rda", rda, 0);
    check("reset_fe", framing_err, 0);
    check("reset_ovr", overrun, 0);
    rst = 1'b0;
    wait_clks(4);

    // Short low glitch must be rejected at the mid-start sample.
    rxd = 1'b0;
    wait_clks(3);
    rxd = 1'b1;
    wait_clks(40);
    check("glitch_rda", rda, 0);
    check("glitch_data", rx_data, 0);

    prev_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre_read) begin
        read_pulse();
        check($sformatf("v%0d_read_rda", i), rda, 0);
        check($sformatf("v%0d_read_fe", i), framing_err, 0);
        check($sformatf("v%0d_read_ovr", i), overrun, 0);
        check($sformatf("v%0d_read_data", i), rx_data, prev_data);
      end
      send_frame(vecs[i].data, vecs[i].stop, 16, vecs[i].strobe_done ? 155 : -1, -1, r154, r155);
      rxd = 1'b1;
      wait_clks(vecs[i].gap);
      if (i == 0) begin
        check("latency_rda_edge154", r154, 0);
        check("latency_rda_edge155", r155, 1);
      end
      check($sformatf("v%0d_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("v%0d_rda", i), rda, vecs[i].exp_rda);
      check($sformatf("v%0d_fe", i), framing_err, vecs[i].exp_fe);
      check($sformatf("v%0d_ovr", i), overrun, vecs[i].exp_ovr);
      prev_data = vecs[i].exp_data;
    end

    // Break: bad stop bit, then line held low for 40 bit times.
    read_pulse();
    send_frame(8'h3C, 1'b0, 16, -1, -1, r154, r155);
    wait_clks(2);
    check("break_data", rx_data, 8'h3C);
    check("break_rda", rda, 1);
    check("break_fe", framing_err, 1);
    read_pulse();
    check("break_read_rda", rda, 0);
    wait_clks(640);
    check("break_hold_rda", rda, 0);
    check("break_hold_ovr", overrun, 0);
    check("break_hold_data", rx_data, 8'h3C);
    rxd = 1'b1;
    wait_clks(8);
    send_frame(8'h96, 1'b1, 16, -1, -1, r154, r155);
    wait_clks(4);
    check("after_break_data", rx_data, 8'h96);
    check("after_break_rda", rda, 1);
    check("after_break_fe", framing_err, 0);

    // Async reset during bit 4 (line high there), then a frame at 1-in-4 ticks.
    send_frame(8'hF0, 1'b1, 16, -1, 88, r154, r155);
    wait_clks(8);
    check("post_rst_rda", rda, 0);
    check("post_rst_data", rx_data, 0);
    en_div = 4;
    wait_clks(8);
    send_frame(8'h5A, 1'b1, 64, -1, -1, r154, r155);
    wait_clks(8);
    check("slow_data", rx_data, 8'h5A);
    check("slow_rda", rda, 1);
    check("slow_fe", framing_err, 0);
    check("slow_ovr", overrun, 0);

    // Enable stuck low: a full frame on the line must not be received.
    read_pulse();
    en_stuck = 1'b1;
    wait_clks(2);
    send_frame(8'h33, 1'b1, 16, -1, -1, r154, r155);
    wait_clks(8);
    check("stuck_rda", rda, 0);
    check("stuck_data", rx_data, 8'h5A);
    en_stuck = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
